// File: rtl/noc_eject_unit_pkg.sv
// ============================================================================
// Module : noc_eject_unit_pkg
// Brief  : NoC flit, header and eject-FSM types shared by the eject unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_eject_unit_pkg;

    localparam int c_message_type_width = 5;
    localparam int c_flit_data_width    = 64;

    typedef logic [c_message_type_width-1:0] message_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    // Header payload layout, LSB first: dst[5:0], src[11:6], type[16:12]
    typedef struct packed {
        message_t mtype;
        xy_t      src;
        xy_t      dst;
    } header_t;

    typedef struct packed {
        preamble_t                     pre;
        logic [c_flit_data_width-1:0]  payload;
    } flit_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BODY    = 2'd1,
        S_DELIVER = 2'd2
    } eject_state_t;

endpackage

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
// ============================================================================
// Module : noc_flit_fifo
// Brief  : Synchronous flit FIFO; push while full is dropped unless a pop
//          happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_eject_unit.sv
// ============================================================================
// Module : noc_eject_unit
// Brief  : Router local-port receiver: credit-flow-controlled flit buffer,
//          head/body/tail reassembly, valid/ready message hand-off.
//          Optional error flags with macro NOC_EJECT_ERRCHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_eject_unit
    import noc_eject_unit_pkg::*;
#(
    parameter int         DATA_WIDTH     = 64,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         MAX_BODY_FLITS = 4,
    parameter logic [5:0] LOCAL_XY       = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [DATA_WIDTH+1:0]                  in_flit,
    output logic                                   credit_out,
    output logic                                   msg_valid,
    input  logic                                   msg_ready,
    output logic [c_message_type_width-1:0]        msg_type,
    output logic [$bits(xy_t)-1:0]                 msg_src,
    output logic [$clog2(MAX_BODY_FLITS+1)-1:0]    msg_len,
    output logic [MAX_BODY_FLITS*DATA_WIDTH-1:0]   msg_data,
    output logic [3:0]                             err
);

    localparam int c_len_w = $clog2(MAX_BODY_FLITS+1);

    eject_state_t                        r_state;
    logic [c_message_type_width-1:0]     r_type;
    logic [$bits(xy_t)-1:0]              r_src;
    logic [c_len_w-1:0]                  r_len;
    logic [MAX_BODY_FLITS*DATA_WIDTH-1:0] r_data;

    logic [DATA_WIDTH+1:0]       w_flit;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_pop;
    preamble_t                   w_pre;
    header_t                     w_hdr;
    logic                        w_room;

    noc_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_flit),
        .pop   (w_pop),
        .dout  (w_flit),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Pops are gated by rst so flits lost to a reset never return credits
    assign w_pop      = !rst && !w_empty && (r_state != S_DELIVER);
    assign credit_out = w_pop;
    assign w_pre      = preamble_t'(w_flit[DATA_WIDTH +: 2]);
    assign w_hdr      = header_t'(w_flit[$bits(header_t)-1:0]);
    assign w_room     = (r_len < c_len_w'(MAX_BODY_FLITS));

    assign msg_valid  = (r_state == S_DELIVER);
    assign msg_type   = r_type;
    assign msg_src    = r_src;
    assign msg_len    = r_len;
    assign msg_data   = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_type  <= '0;
            r_src   <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_BODY: begin
                    if (w_pop) begin
                        if (w_pre.head) begin
                            // A head in S_BODY abandons the partial message
                            r_type  <= w_hdr.mtype;
                            r_src   <= w_hdr.src;
                            r_len   <= '0;
                            r_state <= w_pre.tail ? S_DELIVER : S_BODY;
                        end else if (r_state == S_BODY) begin
                            if (w_room) begin
                                r_data[int'(r_len)*DATA_WIDTH +: DATA_WIDTH] <= w_flit[DATA_WIDTH-1:0];
                                r_len <= r_len + c_len_w'(1);
                            end
                            if (w_pre.tail) begin
                                r_state <= S_DELIVER;
                            end
                        end
                    end
                end
                S_DELIVER: begin
                    if (msg_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef NOC_EJECT_ERRCHK_EN
    logic [3:0] r_err;
    logic       w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (in_valid && w_full && !w_pop) begin
                r_err[0] <= 1'b1;
            end
            if (w_pop && !w_pre.head && (r_state == S_IDLE)) begin
                r_err[1] <= 1'b1;
            end
            if (w_pop && w_pre.head && (r_state == S_BODY)) begin
                r_err[2] <= 1'b1;
            end
            if (w_pop && w_pre.head && (w_hdr.dst != LOCAL_XY)) begin
                r_err[3] <= 1'b1;
            end
            if (w_pop && !w_pre.head && (r_state == S_BODY) && !w_room) begin
                r_err[3] <= 1'b1;
            end
        end
    end

    assign err      = r_err;
    assign w_unused = &{1'b0, w_count};
`else
    logic w_unused;

    assign err      = '0;
    assign w_unused = &{1'b0, w_count, w_full, w_hdr.dst, LOCAL_XY};
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_eject_unit.sv
// ============================================================================
// Module : tb_noc_eject_unit
// Brief  : Self-checking bench for noc_eject_unit: credit-respecting router
//          model, packet-level reference model, directed and random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noc_eject_unit;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;
    localparam int LW    = 3;
`ifdef NOC_EJECT_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [DW+1:0]        in_flit;
    logic                 credit_out;
    logic                 msg_valid;
    logic                 msg_ready;
    logic [4:0]           msg_type;
    logic [5:0]           msg_src;
    logic [LW-1:0]        msg_len;
    logic [MAXB*DW-1:0]   msg_data;
    logic [3:0]           err;

    noc_eject_unit #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .MAX_BODY_FLITS (MAXB),
        .LOCAL_XY       (6'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .credit_out (credit_out),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_type   (msg_type),
        .msg_src    (msg_src),
        .msg_len    (msg_len),
        .msg_data   (msg_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  mtype;
        logic [5:0]  src;
        int          len;
        logic [63:0] data [MAXB];
    } msg_t;

    int         total   = 0;
    int         passed  = 0;
    int         credits = DEPTH;
    int         pulses  = 0;
    msg_t       exp_q[$];
    msg_t       m_cur;
    bit         m_open  = 1'b0;
    logic [3:0] exp_err = 4'd0;
    bit         done    = 1'b0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] hdr(logic [4:0] ty, logic [5:0] src, logic [5:0] dst);
        return {47'd0, ty, src, dst};
    endfunction

    // Packet-level reference: what message (if any) a flit stream yields
    function void model_flit(logic h, logic t, logic [63:0] p);
        if (h) begin
            if (m_open) exp_err[2] = 1'b1;
            if (p[5:0] != 6'd0) exp_err[3] = 1'b1;
            m_cur.mtype = p[16:12];
            m_cur.src   = p[11:6];
            m_cur.len   = 0;
            m_open      = 1'b1;
        end else if (!m_open) begin
            exp_err[1] = 1'b1;
            return;
        end else if (m_cur.len < MAXB) begin
            m_cur.data[m_cur.len] = p;
            m_cur.len++;
        end else begin
            exp_err[3] = 1'b1;
        end
        if (t) begin
            exp_q.push_back(m_cur);
            m_open = 1'b0;
        end
    endfunction

    // Router side: credit return monitor
    always @(negedge clk) begin
        if (!rst && credit_out) begin
            credits++;
            pulses++;
            if (credits > DEPTH) begin
                total++;
                $display("FAIL credit_overflow: got %0d credits, max %0d", credits, DEPTH);
            end
        end
    end

    // Compare process: every delivered-message cycle against the model
    always @(negedge clk) begin
        if (!rst && msg_valid) begin
            chk("exp_pending", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                chk("msg_type", 256'(msg_type), 256'(exp_q[0].mtype));
                chk("msg_src",  256'(msg_src),  256'(exp_q[0].src));
                chk("msg_len",  256'(msg_len),  256'(exp_q[0].len));
                for (int k = 0; k < exp_q[0].len; k++)
                    chk("msg_data", 256'(msg_data[k*DW +: DW]), 256'(exp_q[0].data[k]));
                if (msg_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(logic h, logic t, logic [63:0] p, bit force_drv = 1'b0);
        int g = 0;
        if (!force_drv) begin
            while (credits == 0 && g < 200) begin
                @(posedge clk); #1; g++;
            end
            if (credits == 0) begin
                total++;
                $display("FAIL credit_wait: got %0d credits after %0d cycles, required >0", credits, g);
            end
        end
        in_valid = 1'b1;
        in_flit  = {h, t, p};
        if (!force_drv) begin
            credits--;
            model_flit(h, t, p);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int c = 0;
        @(negedge clk);
        while (!msg_valid && c < 100) begin
            @(negedge clk); c++;
        end
        if (!msg_valid) begin
            total++;
            $display("FAIL wait_valid: got msg_valid=0 after %0d cycles, required 1", c);
        end
    endtask

    task automatic drain();
        int g = 0;
        @(posedge clk); #1;
        msg_ready = 1'b1;
        while ((exp_q.size() != 0 || credits != DEPTH || msg_valid) && g < 300) begin
            @(negedge clk); g++;
        end
        chk("drain_queue",   256'(exp_q.size()), 256'(0));
        chk("drain_credits", 256'(credits),      256'(DEPTH));
        @(posedge clk); #1;
        msg_ready = 1'b0;
    endtask

    task automatic chk_err(string name);
        chk(name, 256'(err), ERRCHK ? 256'(exp_err) : 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_flit   = '0;
        msg_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_msg_valid",  256'(msg_valid),  256'(0));
        chk("rst_credit_out", 256'(credit_out), 256'(0));
        chk("rst_msg_len",    256'(msg_len),    256'(0));
        chk("rst_msg_type",   256'(msg_type),   256'(0));
        chk("rst_msg_src",    256'(msg_src),    256'(0));
        chk("rst_msg_data",   256'(msg_data),   256'(0));
        chk("rst_err",        256'(err),        256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single flit message, two-cycle latency
        p0 = pulses;
        send(1'b1, 1'b1, hdr(5'h03, {3'd2, 3'd1}, 6'd0));
        @(negedge clk);
        chk("t1_valid_early", 256'(msg_valid), 256'(0));
        @(negedge clk);
        chk("t1_valid",   256'(msg_valid), 256'(1));
        chk("t1_type",    256'(msg_type),  256'(5'h03));
        chk("t1_src",     256'(msg_src),   256'(6'h11));
        chk("t1_len",     256'(msg_len),   256'(0));
        chk("t1_credits", 256'(pulses - p0), 256'(1));
        drain();

        // 2: head + 3 body + tail
        p0 = pulses;
        send(1'b1, 1'b0, hdr(5'h01, 6'h05, 6'd0));
        for (int i = 0; i < 4; i++) send(1'b0, (i == 3), 64'hA0 + 64'(i));
        wait_valid();
        chk("t2_len", 256'(msg_len), 256'(4));
        for (int k = 0; k < 4; k++) chk("t2_slot", 256'(msg_data[k*DW +: DW]), 256'(64'hA0 + 64'(k)));
        chk("t2_credits", 256'(pulses - p0), 256'(5));
        drain();

        // 3: delivery stalled, second packet fills the FIFO
        send(1'b1, 1'b1, hdr(5'h07, 6'h09, 6'd0));
        wait_valid();
        @(posedge clk); #1;
        send(1'b1, 1'b0, hdr(5'h02, 6'h0A, 6'd0));
        send(1'b0, 1'b0, 64'h11);
        send(1'b0, 1'b0, 64'h22);
        send(1'b0, 1'b1, 64'h33);
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("t3_no_pops",  256'(pulses - p0), 256'(0));
        chk("t3_credits0", 256'(credits),     256'(0));
        chk("t3_held",     256'(msg_valid),   256'(1));
        chk("t3_held_type", 256'(msg_type),   256'(5'h07));
        drain();

        // 4: body overflow saturates at MAX_BODY_FLITS
        send(1'b1, 1'b0, hdr(5'h04, 6'h12, 6'd0));
        for (int i = 0; i < 7; i++) send(1'b0, (i == 6), 64'hB0 + 64'(i));
        wait_valid();
        chk("t4_len", 256'(msg_len), 256'(4));
        for (int k = 0; k < 4; k++) chk("t4_slot", 256'(msg_data[k*DW +: DW]), 256'(64'hB0 + 64'(k)));
        drain();
        chk_err("t4_err");

        // 5: stray body, then a head abandoned by a second head
        send(1'b0, 1'b0, 64'hC0);
        send(1'b1, 1'b0, hdr(5'h09, 6'h01, 6'd0));
        send(1'b0, 1'b0, 64'hC1);
        send(1'b1, 1'b1, hdr(5'h0A, 6'h22, 6'd0));
        wait_valid();
        chk("t5_len",  256'(msg_len),  256'(0));
        chk("t5_type", 256'(msg_type), 256'(5'h0A));
        chk("t5_src",  256'(msg_src),  256'(6'h22));
        drain();
        chk_err("t5_err");

        // 6a: write while full is dropped
        send(1'b1, 1'b1, hdr(5'h05, 6'h03, 6'd0));
        wait_valid();
        @(posedge clk); #1;
        send(1'b1, 1'b0, hdr(5'h06, 6'h04, 6'd0));
        send(1'b0, 1'b0, 64'hD0);
        send(1'b0, 1'b0, 64'hD1);
        send(1'b0, 1'b1, 64'hD2);
        send(1'b1, 1'b1, hdr(5'h1F, 6'h3F, 6'd0), 1'b1);
        exp_err[0] = 1'b1;
        chk("t6_credits0", 256'(credits), 256'(0));
        drain();
        chk_err("t6_err");

        // 6b: reset mid-packet
        send(1'b1, 1'b0, hdr(5'h08, 6'h06, 6'd0));
        send(1'b0, 1'b0, 64'hE0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_credit", 256'(credit_out), 256'(0));
        @(negedge clk);
        chk("t6_rst_valid",  256'(msg_valid), 256'(0));
        chk("t6_rst_len",    256'(msg_len),   256'(0));
        chk("t6_rst_type",   256'(msg_type),  256'(0));
        chk("t6_rst_src",    256'(msg_src),   256'(0));
        chk("t6_rst_data",   256'(msg_data),  256'(0));
        chk("t6_rst_err",    256'(err),       256'(0));
        credits = DEPTH;
        exp_q.delete();
        m_open  = 1'b0;
        exp_err = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(1'b1, 1'b1, hdr(5'h0B, 6'h07, 6'd0));
        drain();

        // Random traffic with random tile backpressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic        h, t;
                    logic [63:0] p;
                    h = ($urandom_range(0, 3) == 0);
                    t = ($urandom_range(0, 2) == 0);
                    p = {$urandom, $urandom};
                    if (h && $urandom_range(0, 7) != 0) p[5:0] = 6'd0;
                    send(h, t, p);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    msg_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        chk_err("rand_err");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
